spi_adc_responder: RTL and testbench
====================================

Name: spi_adc_responder

Overview:
SPI mode-0 slave that emulates the 12-bit serial ADC read by the existing SPI master. It answers each CS-framed transfer with 4 leading zeros followed by a 12-bit sample, MSB first. It also captures the 16 MOSI bits for loopback and self-test. It runs on the system clock and oversamples SCK/CS/MOSI, so one clock domain serves both the bench and on-chip loopback.

Parameters:
FRAME_BITS, 16, SCK cycles per complete frame
DATA_BITS, 12, sample width; sent in the last DATA_BITS slots; leading slots are 0
SYNC_STAGES, 2, synchronizer depth on sck/cs/mosi (min 2)

Ports:
clk  in  1  system clock; must be >= 8x SCK frequency
reset  in  1  synchronous, active-low reset
sck  in  1  SPI clock from master, idle low
cs  in  1  chip select from master, active-low
mosi  in  1  master-out data
miso  out  1  slave-out data
miso_oe  out  1  high while frame selected (tri-state enable)
i_sample  in  DATA_BITS  next sample to serve
i_sample_valid  in  1  load i_sample into holding register
o_sample_ready  out  1  holding register accepts a load this cycle
o_rx_data  out  FRAME_BITS  last complete MOSI word, MSB first
o_rx_valid  out  1  one-cycle pulse when o_rx_data updates
o_frame_abort  out  1  one-cycle pulse when CS rises before FRAME_BITS bits
o_busy  out  1  frame in progress (state ACTIVE)

Behaviour:
- Reset (reset==0 at posedge clk): state IDLE. miso=0, miso_oe=0, o_rx_data=0, o_rx_valid=0, o_frame_abort=0, o_busy=0, o_sample_ready=1, holding register=0, bit_cnt=0.
- Synchronizer reset values: cs chain=1, sck chain=0, mosi chain=0. Edge-detect history uses the same values. If CS is held low through reset, no frame starts until CS goes high and then low again.
- Edges are detected on the last synchronizer stage. Response latency is SYNC_STAGES+1 clk after a pin edge.
- o_sample_ready = !o_busy. A load happens when i_sample_valid && o_sample_ready. Loads while busy are dropped.
- FSM IDLE -> ACTIVE on a synced CS falling edge:
  - tx_shift <= {zeros, holding register}, using the value before any load in the same cycle.
  - bit_cnt <= 0, miso_oe <= 1, miso <= tx_shift MSB (0).
- ACTIVE, on synced SCK rising edge with bit_cnt < FRAME_BITS:
  - rx_shift <= {rx_shift, mosi_sync}; bit_cnt++.
  - When bit_cnt becomes FRAME_BITS: o_rx_data <= new rx_shift, o_rx_valid=1 for one cycle.
- ACTIVE, on synced SCK falling edge with bit_cnt < FRAME_BITS: tx_shift shifts left and miso presents the new MSB.
- Once bit_cnt == FRAME_BITS, miso=0 and further SCK edges are ignored (no second rx_valid, no counter wrap).
- ACTIVE -> IDLE on a synced CS rising edge:
  - miso=0, miso_oe=0.
  - If bit_cnt < FRAME_BITS, o_frame_abort=1 for one cycle and o_rx_data is unchanged.
- A CS rising edge and an SCK edge in the same clk: the CS edge wins and the SCK edge is ignored.
- Reset during ACTIVE: immediate return to the reset values above. A partial frame produces no rx_valid and no abort pulse.
- Back-to-back frames need only one clk of CS high after sync; each new frame uses the holding register contents at that frame's start.

Test Plan:
- Hold 0xABC loaded; master runs 16 SCK at clk/10 with mosi=0x1234 -> master samples miso 0000_1010_1011_1100. o_rx_data=0x1234 with a single o_rx_valid pulse. o_frame_abort never asserts. miso_oe is high only inside CS.
- CS rises after 7 SCK rising edges -> one o_frame_abort pulse, no o_rx_valid, o_rx_data retains its previous value, miso=0 and miso_oe=0 after sync latency.
- Load 0x111, start frame, pulse i_sample_valid with 0x222 mid-frame -> o_sample_ready=0 and the load is dropped. That frame sends 0x111 and the next frame also sends 0x111. After loading 0x333 in IDLE, the following frame sends 0x333.
- Assert reset at bit 9 of a frame, release, complete that CS window -> all outputs at reset values, no rx_valid. The next full CS frame works normally.
- 20 SCK pulses within one CS window -> exactly one o_rx_valid after the 16th rising edge, o_rx_data equals the first 16 MOSI bits, miso=0 for bits 17-20, no abort.
- CS falling edge and i_sample_valid (0x5A5) in the same clk, with holding register at 0x0F0 -> the frame sends 0x0F0, and the next frame sends 0x5A5.

Source files
------------

// File: rtl/spi_adc_responder.sv
// SPI mode-0 slave that emulates a serial ADC: it returns zero-padded samples
// and captures MOSI words, with all SPI pins oversampled on the system clock.
module spi_adc_responder #(
    parameter int FRAME_BITS  = 16,
    parameter int DATA_BITS   = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sck,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_BITS-1:0]  i_sample,
    input  logic                  i_sample_valid,
    output logic                  o_sample_ready,
    output logic [FRAME_BITS-1:0] o_rx_data,
    output logic                  o_rx_valid,
    output logic                  o_frame_abort,
    output logic                  o_busy
);

    localparam int CW = $clog2(FRAME_BITS + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   cs_prev_q;
    logic                   sck_prev_q;
    logic                   armed_q;
    logic [DATA_BITS-1:0]   hold_q;
    logic [FRAME_BITS-1:0]  tx_q;
    logic [FRAME_BITS-1:0]  rx_q;
    logic [CW-1:0]          cnt_q;
    logic                   miso_q;
    logic                   oe_q;
    logic [FRAME_BITS-1:0]  rx_data_q;
    logic                   rx_valid_q;
    logic                   abort_q;

    logic                   cs_s;
    logic                   sck_s;
    logic                   mosi_s;
    logic                   cs_fall;
    logic                   cs_rise;
    logic                   sck_rise;
    logic                   sck_fall;
    logic                   cnt_open;
    logic [FRAME_BITS-1:0]  rx_d;

    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    // A CS low held through reset must not look like a fresh frame start.
    assign cs_fall  = armed_q & cs_prev_q & ~cs_s;
    assign cs_rise  = ~cs_prev_q & cs_s;
    assign sck_rise = ~sck_prev_q & sck_s;
    assign sck_fall = sck_prev_q & ~sck_s;
    assign cnt_open = (cnt_q < CW'(FRAME_BITS));
    assign rx_d     = {rx_q[FRAME_BITS-2:0], mosi_s};

    assign o_busy         = (state_q == ACTIVE);
    assign o_sample_ready = ~o_busy;
    assign miso           = miso_q;
    assign miso_oe        = oe_q;
    assign o_rx_data      = rx_data_q;
    assign o_rx_valid     = rx_valid_q;
    assign o_frame_abort  = abort_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cs_sync_q   <= '1;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            fill_q      <= '0;
            cs_prev_q   <= 1'b1;
            sck_prev_q  <= 1'b0;
            armed_q     <= 1'b0;
            hold_q      <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            cnt_q       <= '0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            cs_prev_q   <= cs_s;
            sck_prev_q  <= sck_s;
            armed_q     <= armed_q | (fill_q[SYNC_STAGES-1] & cs_s);
            rx_valid_q  <= 1'b0;
            abort_q     <= 1'b0;

            if (i_sample_valid && state_q == IDLE) begin
                hold_q <= i_sample;
            end

            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q <= ACTIVE;
                        tx_q    <= FRAME_BITS'(hold_q);
                        cnt_q   <= '0;
                        oe_q    <= 1'b1;
                        miso_q  <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state_q <= IDLE;
                        miso_q  <= 1'b0;
                        oe_q    <= 1'b0;
                        abort_q <= cnt_open;
                    end else if (sck_rise && cnt_open) begin
                        rx_q  <= rx_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(FRAME_BITS - 1)) begin
                            rx_data_q  <= rx_d;
                            rx_valid_q <= 1'b1;
                            miso_q     <= 1'b0;
                        end
                    end else if (sck_fall && cnt_open) begin
                        tx_q   <= {tx_q[FRAME_BITS-2:0], 1'b0};
                        miso_q <= tx_q[FRAME_BITS-2];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_adc_responder.sv
// Bench for spi_adc_responder: a bit-banged SPI master against a frame-level
// model of what the ADC should return and capture.
module tb_spi_adc_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sck = 1'b0;
    logic        cs = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic        miso_oe;
    logic [11:0] i_sample = '0;
    logic        i_sample_valid = 1'b0;
    logic        o_sample_ready;
    logic [15:0] o_rx_data;
    logic        o_rx_valid;
    logic        o_frame_abort;
    logic        o_busy;

    int n_cmp = 0;
    int n_err = 0;
    int rx_pulses = 0;
    int ab_pulses = 0;
    int oe_bad = 0;
    int cs_hi_run = 0;

    logic [11:0] ref_hold = '0;
    logic [15:0] ref_rx = '0;

    spi_adc_responder #(
        .FRAME_BITS(16),
        .DATA_BITS(12),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sck(sck),
        .cs(cs),
        .mosi(mosi),
        .miso(miso),
        .miso_oe(miso_oe),
        .i_sample(i_sample),
        .i_sample_valid(i_sample_valid),
        .o_sample_ready(o_sample_ready),
        .o_rx_data(o_rx_data),
        .o_rx_valid(o_rx_valid),
        .o_frame_abort(o_frame_abort),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_rx_valid) rx_pulses <= rx_pulses + 1;
        if (o_frame_abort) ab_pulses <= ab_pulses + 1;
    end

    always @(negedge clk) begin
        if (cs) cs_hi_run <= cs_hi_run + 1;
        else cs_hi_run <= 0;
        if (cs_hi_run > 4 && miso_oe) oe_bad <= oe_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [11:0] v);
        @(negedge clk);
        i_sample = v;
        i_sample_valid = 1'b1;
        ref_hold = v;
        @(negedge clk);
        i_sample_valid = 1'b0;
    endtask

    task automatic sck_bit(input logic m, output logic so);
        mosi = m;
        repeat (5) @(negedge clk);
        sck = 1'b1;
        so = miso;
        repeat (5) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] mo, input int nrise,
                             input int mid_at, input logic [11:0] mid_val,
                             input bit start_load, input logic [11:0] start_val);
        logic [15:0] exp_tx;
        logic [15:0] got;
        logic [31:0] mask;
        logic        tail;
        logic        so;
        logic        m;
        int          rxp0;
        int          ab0;
        exp_tx = {4'b0, ref_hold};
        got = '0;
        tail = 1'b0;
        rxp0 = rx_pulses;
        ab0 = ab_pulses;
        @(negedge clk);
        cs = 1'b0;
        if (start_load) begin
            @(negedge clk);
            @(negedge clk);
            i_sample = start_val;
            i_sample_valid = 1'b1;
            ref_hold = start_val;
            @(negedge clk);
            i_sample_valid = 1'b0;
            repeat (3) @(negedge clk);
        end else begin
            repeat (6) @(negedge clk);
        end
        check("busy_in", 32'(o_busy), 32'd1);
        check("oe_in", 32'(miso_oe), 32'd1);
        for (int i = 0; i < nrise; i++) begin
            if (i == mid_at) begin
                i_sample = mid_val;
                i_sample_valid = 1'b1;
                check("ready_busy", 32'(o_sample_ready), 32'd0);
                @(negedge clk);
                i_sample_valid = 1'b0;
            end
            m = (i < 16) ? mo[15-i] : 1'($urandom);
            sck_bit(m, so);
            if (i < 16) got[15-i] = so;
            else tail = tail | so;
        end
        repeat (5) @(negedge clk);
        cs = 1'b1;
        repeat (6) @(negedge clk);
        mask = 32'hFFFF_0000 >> ((nrise < 16) ? nrise : 16);
        mask = mask & 32'h0000_FFFF;
        check("tx_word", 32'(got) & mask, 32'(exp_tx) & mask);
        if (nrise > 16) check("tx_tail", 32'(tail), 32'd0);
        if (nrise >= 16) begin
            ref_rx = mo;
            check("rx_pulse", 32'(rx_pulses - rxp0), 32'd1);
            check("abort_none", 32'(ab_pulses - ab0), 32'd0);
        end else begin
            check("rx_none", 32'(rx_pulses - rxp0), 32'd0);
            check("abort_pulse", 32'(ab_pulses - ab0), 32'd1);
        end
        check("rx_data", 32'(o_rx_data), 32'(ref_rx));
        check("miso_idle", 32'(miso), 32'd0);
        check("oe_idle", 32'(miso_oe), 32'd0);
        check("busy_idle", 32'(o_busy), 32'd0);
    endtask

    initial begin
        logic so;
        int   rxp0;
        int   ab0;
        int   nr;

        repeat (3) @(negedge clk);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_oe", 32'(miso_oe), 32'd0);
        check("rst_rx", 32'(o_rx_data), 32'd0);
        check("rst_valid", 32'(o_rx_valid), 32'd0);
        check("rst_abort", 32'(o_frame_abort), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_ready", 32'(o_sample_ready), 32'd1);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        load(12'hABC);
        run_frame(16'h1234, 16, -1, '0, 1'b0, '0);

        run_frame(16'($urandom), 7, -1, '0, 1'b0, '0);

        load(12'h111);
        run_frame(16'($urandom), 16, 5, 12'h222, 1'b0, '0);
        run_frame(16'($urandom), 16, -1, '0, 1'b0, '0);
        load(12'h333);
        run_frame(16'($urandom), 16, -1, '0, 1'b0, '0);

        load(12'h3C3);
        rxp0 = rx_pulses;
        ab0 = ab_pulses;
        cs = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 9; i++) sck_bit(1'($urandom), so);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_miso", 32'(miso), 32'd0);
        check("mid_rst_oe", 32'(miso_oe), 32'd0);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_ready", 32'(o_sample_ready), 32'd1);
        check("mid_rst_rx", 32'(o_rx_data), 32'd0);
        reset = 1'b1;
        ref_hold = '0;
        ref_rx = '0;
        for (int i = 9; i < 16; i++) sck_bit(1'($urandom), so);
        check("stale_cs_oe", 32'(miso_oe), 32'd0);
        check("stale_cs_busy", 32'(o_busy), 32'd0);
        repeat (5) @(negedge clk);
        cs = 1'b1;
        repeat (6) @(negedge clk);
        check("mid_rst_nvalid", 32'(rx_pulses - rxp0), 32'd0);
        check("mid_rst_nabort", 32'(ab_pulses - ab0), 32'd0);
        check("mid_rst_rx2", 32'(o_rx_data), 32'd0);
        load(12'($urandom));
        run_frame(16'($urandom), 16, -1, '0, 1'b0, '0);

        run_frame(16'($urandom), 20, -1, '0, 1'b0, '0);

        load(12'h0F0);
        run_frame(16'($urandom), 16, -1, '0, 1'b1, 12'h5A5);
        run_frame(16'($urandom), 16, -1, '0, 1'b0, '0);

        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 1) == 1) load(12'($urandom));
            case ($urandom_range(0, 3))
                0: nr = $urandom_range(1, 15);
                1: nr = $urandom_range(17, 20);
                default: nr = 16;
            endcase
            run_frame(16'($urandom), nr, -1, '0, 1'b0, '0);
        end

        check("oe_outside_cs", 32'(oe_bad), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
